// File: rtl/console_pkg.sv
// Shared constants, state encoding and address packing for the text console
// writer and the character-cell video generator.
package console_pkg;

  localparam int COLUMNS    = 48;
  localparam int ROWS       = 32;
  localparam int CHAR_WIDTH = 7;
  localparam int COL_W      = 6;
  localparam int ROW_W      = 5;
  localparam int ADDR_W     = ROW_W + COL_W;

  localparam logic [CHAR_WIDTH-1:0] BLANK_CHAR = 7'h20;
  localparam logic [CHAR_WIDTH-1:0] LF         = 7'h0A;
  localparam logic [CHAR_WIDTH-1:0] CR         = 7'h0D;
  localparam logic [CHAR_WIDTH-1:0] BS         = 7'h08;
  localparam logic [CHAR_WIDTH-1:0] FF         = 7'h0C;

  typedef enum logic [1:0] {
    CLEAR_ALL,
    IDLE,
    CLEAR_LINE
  } state_t;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/text_console_writer_if.sv
// Character stream handshake plus character-table write port.
// master = character producer / table owner side, slave = console writer.
interface text_console_writer_if;
  import console_pkg::*;

  logic                  char_valid;
  logic [CHAR_WIDTH-1:0] char_data;
  logic                  char_ready;
  logic                  write_enable;
  logic [ADDR_W-1:0]     write_address;
  logic [CHAR_WIDTH-1:0] write_data;

  modport master (
    output char_valid, char_data,
    input  char_ready, write_enable, write_address, write_data
  );

  modport slave (
    input  char_valid, char_data,
    output char_ready, write_enable, write_address, write_data
  );

endinterface

// File: rtl/text_console_writer_cell_clear_counter.sv
// Row-major cell sweep used by full-screen and single-line clears; last flags
// the final cell of the current sweep.
module text_console_writer_cell_clear_counter
  import console_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             step,
  input  logic             line_mode,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);

  assign last = (col == COL_W'(COLUMNS - 1)) && (line_mode || row == ROW_W'(ROWS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      row <= '0;
      col <= '0;
    end else if (step) begin
      if (last) begin
        row <= '0;
        col <= '0;
      end else if (col == COL_W'(COLUMNS - 1)) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/text_console_writer.sv
// Cursor-driven writer into the 48x32 character table with hardware scroll.
// Optional build macro: FORM_FEED_EN (0x0C homes the cursor and clears all).
module text_console_writer
  import console_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  text_console_writer_if.slave  bus,
  output logic [ROW_W-1:0]      top_row,
  output logic [COL_W-1:0]      cursor_col,
  output logic [ROW_W-1:0]      cursor_row
);

  state_t           state;
  logic [ROW_W-1:0] cnt_row;
  logic [COL_W-1:0] cnt_col;
  logic             cnt_last;
  logic             transfer;
  logic [ROW_W-1:0] phys_row;

  logic                  dec_write;
  logic [COL_W-1:0]      dec_col;
  logic [CHAR_WIDTH-1:0] dec_data;
  logic [COL_W-1:0]      nxt_col;
  logic                  dec_newline;
`ifdef FORM_FEED_EN
  logic                  dec_ff;
`endif

  text_console_writer_cell_clear_counter u_counter (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (state == IDLE),
    .step      (state != IDLE),
    .line_mode (state == CLEAR_LINE),
    .row       (cnt_row),
    .col       (cnt_col),
    .last      (cnt_last)
  );

  assign transfer = (state == IDLE) && bus.char_valid && bus.char_ready;
  assign phys_row = top_row + cursor_row;  // natural 5-bit wrap

  // NOTE: every combinational output gets a default first so no path through
  // the decode can leave a value held, which would infer a latch.
  always_comb begin
    dec_write   = 1'b0;
    dec_col     = cursor_col;
    dec_data    = bus.char_data;
    nxt_col     = cursor_col;
    dec_newline = 1'b0;
`ifdef FORM_FEED_EN
    dec_ff      = 1'b0;
`endif
    if (bus.char_data >= 7'h20 && bus.char_data <= 7'h7E) begin
      dec_write = 1'b1;
      if (cursor_col == COL_W'(COLUMNS - 1)) begin
        nxt_col     = '0;
        dec_newline = 1'b1;
      end else begin
        nxt_col = cursor_col + 1'b1;
      end
    end else begin
      case (bus.char_data)
        LF: dec_newline = 1'b1;
        CR: nxt_col = '0;
        BS: begin
          if (cursor_col != '0) begin
            nxt_col   = cursor_col - 1'b1;
            dec_col   = cursor_col - 1'b1;
            dec_data  = BLANK_CHAR;
            dec_write = 1'b1;
          end
        end
        FF: begin
`ifdef FORM_FEED_EN
          dec_ff = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  // The table itself lives in the video generator; only the write port and
  // cursor/scroll registers are reset here.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state             <= CLEAR_ALL;
      bus.char_ready    <= 1'b0;
      bus.write_enable  <= 1'b0;
      bus.write_address <= '0;
      bus.write_data    <= '0;
      top_row           <= '0;
      cursor_col        <= '0;
      cursor_row        <= '0;
    end else begin
      bus.write_enable <= 1'b0;
      case (state)
        CLEAR_ALL: begin
          bus.write_enable  <= 1'b1;
          bus.write_address <= pack_addr(cnt_row, cnt_col);
          bus.write_data    <= BLANK_CHAR;
          if (cnt_last) state <= IDLE;
        end
        IDLE: begin
          bus.char_ready <= 1'b1;
          if (transfer) begin
            if (dec_write) begin
              bus.write_enable  <= 1'b1;
              bus.write_address <= pack_addr(phys_row, dec_col);
              bus.write_data    <= dec_data;
            end
            cursor_col <= nxt_col;
`ifdef FORM_FEED_EN
            if (dec_ff) begin
              cursor_col     <= '0;
              cursor_row     <= '0;
              top_row        <= '0;
              bus.char_ready <= 1'b0;
              state          <= CLEAR_ALL;
            end else
`endif
            if (dec_newline) begin
              if (cursor_row != ROW_W'(ROWS - 1)) begin
                cursor_row <= cursor_row + 1'b1;
              end else begin
                // Recycle the old top row as the new bottom row.
                bus.char_ready <= 1'b0;
                state          <= CLEAR_LINE;
              end
            end
          end
        end
        CLEAR_LINE: begin
          bus.write_enable  <= 1'b1;
          bus.write_address <= pack_addr(top_row, cnt_col);
          bus.write_data    <= BLANK_CHAR;
          if (cnt_last) begin
            top_row <= top_row + 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= CLEAR_ALL;
      endcase
    end
  end

endmodule
